// File: rtl/map_pkg.sv
// Shared sprite codes, default maze geometry and cell address helper for the tile store.
package map_pkg;

  localparam int MAP_W_DEF    = 21;
  localparam int MAP_H_DEF    = 21;
  localparam int MAP_SPRITE_W = 3;
  localparam int MAP_COORD_W  = 5;

  localparam logic [MAP_SPRITE_W-1:0] SPR_EMPTY  = 3'd0;
  localparam logic [MAP_SPRITE_W-1:0] SPR_PELLET = 3'd1;
  localparam logic [MAP_SPRITE_W-1:0] SPR_WALL   = 3'd2;

  // Row-major cell index; callers range-check the coordinates first.
  function automatic logic [31:0] map_addr(input logic [MAP_COORD_W-1:0] x,
                                           input logic [MAP_COORD_W-1:0] y,
                                           input int unsigned w);
    return 32'(y) * w + 32'(x);
  endfunction

endpackage

// File: rtl/map_default_rom.sv
// Default tile for each cell address: border walls with pellets inside.
// Combinational, zero latency.
// No handshake, never stalls.
module map_default_rom
  import map_pkg::*;
#(
  parameter int                    MAP_W     = MAP_W_DEF,
  parameter int                    MAP_H     = MAP_H_DEF,
  parameter int                    SPRITE_W  = MAP_SPRITE_W,
  parameter logic [SPRITE_W-1:0]   PELLET    = SPRITE_W'(SPR_PELLET),
  parameter logic [SPRITE_W-1:0]   WALL      = SPRITE_W'(SPR_WALL),
  parameter string                 INIT_FILE = "",
  localparam int                   N         = MAP_W * MAP_H,
  localparam int                   ADDR_W    = $clog2(N)
) (
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [SPRITE_W-1:0] o_tile
);

    logic [ADDR_W-1:0] w_x;
    logic [ADDR_W-1:0] w_y;

    assign w_x = i_addr % ADDR_W'(MAP_W);
    assign w_y = i_addr / ADDR_W'(MAP_W);

    always_comb begin
        if (32'(i_addr) >= 32'(N)) begin
            o_tile = SPRITE_W'(SPR_EMPTY);
        end else if (w_x == '0 || w_x == ADDR_W'(MAP_W - 1) ||
                     w_y == '0 || w_y == ADDR_W'(MAP_H - 1)) begin
            o_tile = WALL;
        end else begin
            o_tile = PELLET;
        end
    end

endmodule

// File: rtl/map_tile_store.sv
// Maze tile RAM: handshaked port A (read acks t+2, write t+3, range error t+1), registered port B read.
// Port A requests outside IDLE are ignored and must be held until a_ack; port B never stalls.
module map_tile_store
  import map_pkg::*;
#(
  parameter int                    MAP_W     = MAP_W_DEF,
  parameter int                    MAP_H     = MAP_H_DEF,
  parameter int                    SPRITE_W  = MAP_SPRITE_W,
  parameter logic [SPRITE_W-1:0]   PELLET    = SPRITE_W'(SPR_PELLET),
  parameter logic [SPRITE_W-1:0]   WALL      = SPRITE_W'(SPR_WALL),
  parameter string                 INIT_FILE = "",
  localparam int                   N         = MAP_W * MAP_H,
  localparam int                   ADDR_W    = $clog2(N),
  localparam int                   CNT_W     = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reinit,
  output logic                   busy,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [MAP_COORD_W-1:0] a_x,
  input  logic [MAP_COORD_W-1:0] a_y,
  input  logic [SPRITE_W-1:0]    a_wdata,
  output logic                   a_ready,
  output logic                   a_ack,
  output logic                   a_err,
  output logic [SPRITE_W-1:0]    a_rdata,
  input  logic [MAP_COORD_W-1:0] b_x,
  input  logic [MAP_COORD_W-1:0] b_y,
  output logic [SPRITE_W-1:0]    b_rdata,
  output logic [CNT_W-1:0]       pellets_left,
  output logic                   level_clear
);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  logic [2:0]             r_state;
  logic [ADDR_W-1:0]      r_init_addr;
  logic [MAP_COORD_W-1:0] r_ax;
  logic [MAP_COORD_W-1:0] r_ay;
  logic                   r_we;
  logic [SPRITE_W-1:0]    r_wdata;
  logic [SPRITE_W-1:0]    r_old;
  logic                   r_err;
  logic [CNT_W-1:0]       r_pellets;
  logic [SPRITE_W-1:0]    r_b_rdata;
  logic [SPRITE_W-1:0]    r_mem [N];

  logic [SPRITE_W-1:0]    w_def_tile;
  logic [ADDR_W-1:0]      w_a_addr;
  logic [ADDR_W-1:0]      w_b_addr;
  logic                   w_a_in_range;
  logic                   w_b_in_range;
  logic                   w_ram_we;
  logic [ADDR_W-1:0]      w_ram_waddr;
  logic [SPRITE_W-1:0]    w_ram_wdata;
  logic                   w_dec;
  logic                   w_inc;

  map_default_rom #(
    .MAP_W     (MAP_W),
    .MAP_H     (MAP_H),
    .SPRITE_W  (SPRITE_W),
    .PELLET    (PELLET),
    .WALL      (WALL),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .i_addr (r_init_addr),
    .o_tile (w_def_tile)
  );

  assign w_a_in_range = (32'(a_x) < 32'(MAP_W)) && (32'(a_y) < 32'(MAP_H));
  assign w_b_in_range = (32'(b_x) < 32'(MAP_W)) && (32'(b_y) < 32'(MAP_H));
  assign w_a_addr     = ADDR_W'(map_addr(r_ax, r_ay, MAP_W));
  assign w_b_addr     = ADDR_W'(map_addr(b_x, b_y, MAP_W));

  // The init sweep and the WR state share the single port-A write path.
  assign w_ram_we    = !reset && !reinit && (r_state == S_INIT || r_state == S_WR);
  assign w_ram_waddr = (r_state == S_INIT) ? r_init_addr : w_a_addr;
  assign w_ram_wdata = (r_state == S_INIT) ? w_def_tile : r_wdata;

  assign w_dec = (r_state == S_WR) && (r_old == PELLET) && (r_wdata != PELLET);
  assign w_inc = (r_state == S_WR) && (r_old != PELLET) && (r_wdata == PELLET);

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
  end

  // Same-cycle A write and B read of one cell return the pre-write value to B.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_rdata <= '0;
    end else if (r_state == S_INIT || !w_b_in_range) begin
      r_b_rdata <= '0;
    end else begin
      r_b_rdata <= r_mem[w_b_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reinit) begin
      r_state     <= S_INIT;
      r_init_addr <= '0;
      r_pellets   <= '0;
      r_err       <= 1'b0;
      r_old       <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_def_tile == PELLET) begin
            r_pellets <= r_pellets + CNT_W'(1);
          end
          if (r_init_addr == ADDR_W'(N - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_init_addr <= r_init_addr + ADDR_W'(1);
          end
        end
        S_IDLE: begin
          if (a_req) begin
            r_ax    <= a_x;
            r_ay    <= a_y;
            r_we    <= a_we;
            r_wdata <= a_wdata;
            if (w_a_in_range) begin
              r_err   <= 1'b0;
              r_state <= S_RD;
            end else begin
              r_err   <= 1'b1;
              r_old   <= '0;
              r_state <= S_ACK;
            end
          end
        end
        S_RD: begin
          r_old   <= r_mem[w_a_addr];
          r_state <= r_we ? S_WR : S_ACK;
        end
        S_WR: begin
          if (w_dec) begin
            r_pellets <= r_pellets - CNT_W'(1);
          end else if (w_inc) begin
            r_pellets <= r_pellets + CNT_W'(1);
          end
          r_state <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (reset || reinit)
    w_dec |-> (r_pellets != '0));

  assign busy         = (r_state == S_INIT);
  assign a_ready      = (r_state == S_IDLE);
  assign a_ack        = (r_state == S_ACK);
  assign a_err        = r_err;
  assign a_rdata      = r_old;
  assign b_rdata      = r_b_rdata;
  assign pellets_left = r_pellets;
  assign level_clear  = (r_pellets == '0) && !busy;

endmodule
